// File: rtl/fetch_frontend_pkg.sv
// ============================================================================
// Module   : fetch_frontend_pkg
// Brief    : Shared types for the instruction-fetch front end.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fetch_frontend_pkg;

    localparam int INSTR_BYTES = 4;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] instr_t;

    typedef struct packed {
        addr_t  pc;
        instr_t word;
    } fetch_pkt_t;

endpackage

`default_nettype wire

// File: rtl/fetch_frontend_if.sv
// ============================================================================
// Module   : fetch_frontend_if
// Brief    : Decoupled valid/ready channel carrying one payload of type T.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fetch_frontend_if #(
    parameter type T = logic [31:0]
);
    logic valid;
    logic ready;
    T     data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

`default_nettype wire

// File: rtl/fetch_frontend_sync_fifo.sv
// ============================================================================
// Module   : fetch_frontend_sync_fifo
// Brief    : Small synchronous FIFO with flush, occupancy count, async reset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_frontend_sync_fifo
    import fetch_frontend_pkg::*;
#(
    parameter type T     = addr_t,
    parameter int  DEPTH = 2
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       push,
    input  wire T                           push_data,
    input  wire logic                       pop,
    input  wire logic                       flush,
    output      T                           head,
    output      logic [$clog2(DEPTH+1)-1:0] count,
    output      logic                       full,
    output      logic                       empty
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T              mem_q [DEPTH];
    T              mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Flush has priority over any same-cycle push or pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && !flush && full));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && !flush && empty));

endmodule

`default_nettype wire

// File: rtl/fetch_frontend.sv
// ============================================================================
// Module   : fetch_frontend
// Brief    : PC owner with multiple outstanding fetches, tag FIFO, packet
//            queue and redirect/flush with stale-response discard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_frontend
    import fetch_frontend_pkg::*;
#(
    parameter addr_t BOOT_VEC     = 32'h8000_0000,
    parameter int    MAX_INFLIGHT = 2,
    parameter int    QUEUE_DEPTH  = 4
) (
    input  wire logic                              clk,
    input  wire logic                              rst,
    input  wire logic                              redirect_valid,
    input  wire addr_t                             redirect_pc,
    fetch_frontend_if.master                       mem_req,
    fetch_frontend_if.slave                        mem_resp,
    fetch_frontend_if.master                       fetched,
    output      logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight
);
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam int QC_W  = $clog2(QUEUE_DEPTH + 1);
    localparam int SUM_W = $clog2(QUEUE_DEPTH + MAX_INFLIGHT + 1);

    addr_t            pc_q, pc_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] discard_q, discard_d;

    logic             req_valid;
    logic             req_fire;
    logic             resp_fire;
    logic             keep_resp;
    logic             fetch_fire;
    logic [SUM_W-1:0] credit_used;

    addr_t            tag_head;
    logic [CNT_W-1:0] tag_count;
    logic             tag_full;
    logic             tag_empty;
    fetch_pkt_t       q_head;
    fetch_pkt_t       q_push_data;
    logic [QC_W-1:0]  q_count;
    logic             q_full;
    logic             q_empty;

    // Every outstanding request owns a queue slot, so responses can never
    // find the queue full; issue depends on registered state only.
    assign credit_used = SUM_W'(inflight_q) + SUM_W'(q_count);
    assign req_valid   = !rst
                       && (inflight_q < CNT_W'(MAX_INFLIGHT))
                       && (credit_used < SUM_W'(QUEUE_DEPTH));

    assign mem_req.valid  = req_valid;
    assign mem_req.data   = pc_q;
    assign mem_resp.ready = 1'b1;

    assign req_fire   = req_valid && mem_req.ready;
    assign resp_fire  = mem_resp.valid && mem_resp.ready;
    assign keep_resp  = resp_fire && (discard_q == '0) && !redirect_valid;
    assign fetch_fire = fetched.valid && fetched.ready;

    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(resp_fire);
        discard_d  = discard_q;
        if (redirect_valid) begin
            pc_d      = redirect_pc & ~addr_t'(INSTR_BYTES - 1);
            discard_d = inflight_d;
        end else begin
            if (req_fire) begin
                pc_d = pc_q + addr_t'(INSTR_BYTES);
            end
            if (resp_fire && (discard_q != '0)) begin
                discard_d = discard_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= BOOT_VEC;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    // Tags are held only for requests whose responses will be kept.
    fetch_frontend_sync_fifo #(
        .T     (addr_t),
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_fire && !redirect_valid),
        .push_data (pc_q),
        .pop       (keep_resp),
        .flush     (redirect_valid),
        .head      (tag_head),
        .count     (tag_count),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    assign q_push_data = '{pc: tag_head, word: mem_resp.data};

    fetch_frontend_sync_fifo #(
        .T     (fetch_pkt_t),
        .DEPTH (QUEUE_DEPTH)
    ) u_pkt_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (keep_resp),
        .push_data (q_push_data),
        .pop       (fetch_fire),
        .flush     (redirect_valid),
        .head      (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign fetched.valid = !q_empty;
    assign fetched.data  = q_head;
    assign inflight      = inflight_q;

    a_resp_needs_req: assert property (@(posedge clk) disable iff (rst)
        mem_resp.valid |-> (inflight_q != '0));
    a_discard_bound: assert property (@(posedge clk) disable iff (rst)
        discard_q <= inflight_q);
    a_tag_balance: assert property (@(posedge clk) disable iff (rst)
        tag_count == (inflight_q - discard_q));
    a_tag_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(req_fire && !redirect_valid && tag_full && !keep_resp));
    a_keep_has_room: assert property (@(posedge clk) disable iff (rst)
        keep_resp |-> (!tag_empty && !q_full));

endmodule

`default_nettype wire

// File: tb/tb_fetch_frontend.sv
// ============================================================================
// Module   : tb_fetch_frontend
// Brief    : Randomized bench for fetch_frontend with an epoch-based model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_frontend;
    import fetch_frontend_pkg::*;

    localparam addr_t BOOT_VEC     = 32'h8000_0000;
    localparam int    MAX_INFLIGHT = 2;
    localparam int    QUEUE_DEPTH  = 4;
    localparam int    CNT_W        = $clog2(MAX_INFLIGHT + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             redirect_valid;
    addr_t            redirect_pc;
    logic [CNT_W-1:0] inflight;

    fetch_frontend_if #(.T(addr_t))      mem_req_if ();
    fetch_frontend_if #(.T(instr_t))     mem_resp_if ();
    fetch_frontend_if #(.T(fetch_pkt_t)) fetched_if ();

    fetch_frontend #(
        .BOOT_VEC     (BOOT_VEC),
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .QUEUE_DEPTH  (QUEUE_DEPTH)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req        (mem_req_if),
        .mem_resp       (mem_resp_if),
        .fetched        (fetched_if),
        .inflight       (inflight)
    );

    always #5 clk = ~clk;

    // Memory transaction: issued address, redirect epoch it belongs to, and
    // the cycle its response may be returned.
    typedef struct {
        addr_t addr;
        int    epoch;
        int    due;
    } mreq_t;

    mreq_t      mq[$];
    fetch_pkt_t exp_q[$];
    addr_t      m_pc;
    int         epoch;
    int         cyc;

    int n_cmp = 0;
    int n_bad = 0;

    int    lat_min, lat_max, fready_pct, mready_pct, redir_pct;
    bit    force_redir;
    addr_t force_pc;

    bit         obs_fvalid;
    fetch_pkt_t obs_fdata;
    int         obs_inflight;

    function automatic instr_t mem_word(input addr_t a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        bit    exp_rv, redir, req_fire, resp_fire, fetch_fire, resp_v;
        addr_t rpc;
        mreq_t r;
        int    due;

        @(negedge clk);
        exp_rv = (mq.size() < MAX_INFLIGHT) && (mq.size() + exp_q.size() < QUEUE_DEPTH);
        check("inflight", 64'(inflight), 64'(mq.size()));
        check("req_valid", 64'(mem_req_if.valid), 64'(exp_rv));
        if (exp_rv) check("req_addr", 64'(mem_req_if.data), 64'(m_pc));
        check("fetch_valid", 64'(fetched_if.valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) check("fetch_pkt", 64'(fetched_if.data), 64'(exp_q[0]));
        check("resp_ready", 64'(mem_resp_if.ready), 64'd1);
        obs_fvalid   = fetched_if.valid;
        obs_fdata    = fetched_if.data;
        obs_inflight = int'(inflight);

        redir       = force_redir || ($urandom_range(99) < redir_pct);
        rpc         = force_redir ? force_pc : addr_t'($urandom());
        force_redir = 1'b0;
        resp_v      = (mq.size() > 0) && (mq[0].due <= cyc);

        redirect_valid    = redir;
        redirect_pc       = rpc;
        fetched_if.ready  = ($urandom_range(99) < fready_pct);
        mem_req_if.ready  = ($urandom_range(99) < mready_pct);
        mem_resp_if.valid = resp_v;
        mem_resp_if.data  = resp_v ? mem_word(mq[0].addr) : instr_t'($urandom());

        req_fire   = mem_req_if.valid && mem_req_if.ready;
        resp_fire  = resp_v && mem_resp_if.ready;
        fetch_fire = fetched_if.valid && fetched_if.ready;

        @(posedge clk);
        if (resp_fire) r = mq.pop_front();
        if (req_fire) begin
            due = cyc + $urandom_range(lat_max, lat_min);
            if (mq.size() > 0 && mq[$].due > due) due = mq[$].due;
            mq.push_back('{addr: m_pc, epoch: epoch, due: due});
            m_pc = m_pc + 32'd4;
        end
        if (redir) begin
            exp_q.delete();
            epoch++;
            m_pc = rpc & 32'hFFFF_FFFC;
        end else begin
            if (fetch_fire && exp_q.size() != 0) void'(exp_q.pop_front());
            if (resp_fire && r.epoch == epoch)
                exp_q.push_back('{pc: r.addr, word: mem_word(r.addr)});
        end
        cyc++;
    endtask

    task automatic set_knobs(input int lmin, input int lmax, input int frp, input int mrp, input int rdp);
        lat_min = lmin; lat_max = lmax; fready_pct = frp; mready_pct = mrp; redir_pct = rdp;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic redirect_now(input addr_t pc);
        force_redir = 1'b1;
        force_pc    = pc;
        step();
    endtask

    initial begin
        int  max_inf;
        bit  seen;

        rst = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0;
        mem_req_if.ready = 1'b0; mem_resp_if.valid = 1'b0; mem_resp_if.data = '0;
        fetched_if.ready = 1'b0;
        force_redir = 1'b0; force_pc = '0;
        m_pc = BOOT_VEC; epoch = 0; cyc = 0;
        set_knobs(1, 1, 100, 100, 0);

        repeat (3) @(negedge clk);
        check("rst_req_valid", 64'(mem_req_if.valid), 64'd0);
        check("rst_fetch_valid", 64'(fetched_if.valid), 64'd0);
        check("rst_inflight", 64'(inflight), 64'd0);
        rst = 1'b0;

        // 1: zero-wait memory, decode always ready
        set_knobs(1, 1, 100, 100, 0);
        run(20);

        // 2: 5-cycle memory latency saturates the in-flight limit
        set_knobs(5, 5, 100, 100, 0);
        max_inf = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (obs_inflight > max_inf) max_inf = obs_inflight;
        end
        check("t2_max_inflight", 64'(max_inf), 64'(MAX_INFLIGHT));

        // 3: decode stalled, queue fills, then drains in order
        set_knobs(1, 1, 0, 100, 0);
        run(20);
        @(negedge clk);
        check("t3_stall_req", 64'(mem_req_if.valid), 64'd0);
        check("t3_stall_inflight", 64'(inflight), 64'd0);
        check("t3_queue_head", 64'(fetched_if.valid), 64'd1);
        set_knobs(1, 1, 100, 100, 0);
        run(10);

        // 4: redirect to unaligned 0x1003 with two requests outstanding
        set_knobs(5, 5, 100, 100, 0);
        for (int i = 0; i < 20 && mq.size() < 2; i++) step();
        check("t4_two_inflight", 64'(mq.size()), 64'd2);
        redirect_now(32'h0000_1003);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step();
            if (obs_fvalid) begin
                seen = 1'b1;
                check("t4_first_pc", 64'(obs_fdata.pc), 64'h1000);
            end
        end
        check("t4_pkt_seen", 64'(seen), 64'd1);

        // 5: redirect in steady state, where req and resp both fire
        set_knobs(1, 1, 100, 100, 0);
        run(8);
        redirect_now(32'h0000_0500);
        run(10);

        // 6: back-to-back redirects, one cycle apart, then pc wrap
        set_knobs(2, 3, 100, 100, 0);
        run(6);
        redirect_now(32'h0000_2000);
        redirect_now(32'h0000_3000);
        run(6);
        redirect_now(32'h0000_2000);
        step();
        redirect_now(32'h0000_3000);
        run(12);
        set_knobs(1, 1, 100, 100, 0);
        redirect_now(32'hFFFF_FFFC);
        run(12);

        // Randomized traffic with mixed latency, backpressure and redirects
        for (int b = 0; b < 15; b++) begin
            set_knobs(1, $urandom_range(6, 1), $urandom_range(100, 20),
                      $urandom_range(100, 30), $urandom_range(8, 0));
            run(200);
        end

        // Drain to a quiet state
        set_knobs(1, 1, 100, 0, 0);
        run(20);
        check("end_inflight", 64'(inflight), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
